// File: rtl/store_align_unit.sv
// Store alignment: turns one execute-stage store into one or two word-aligned write beats.
// Accept-to-request latency is one edge. Beats hold stable until the memory grants them.
module store_align_unit #(
  parameter int unsigned SPLIT_MISALIGNED = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_st_valid_i,
  output logic        x_st_ready_o,
  input  logic [31:0] x_st_addr_i,
  input  logic [31:0] x_st_data_i,
  input  logic [2:0]  x_st_funct3_i,
  output logic        dm_req_o,
  input  logic        dm_gnt_i,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic [3:0]  dm_be_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam bit SplitEn = (SPLIT_MISALIGNED != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  hi_be_q;
  logic [31:0] hi_wdata_q;

  logic        legal;
  logic [7:0]  base_mask;
  logic [7:0]  lane_mask;
  logic [31:0] sized_data;
  logic [63:0] wide_data;
  logic        crosses;
  logic        issuable;
  logic        accept;

  // Decode size into a right-justified lane mask and size-masked data, then shift by offset.
  always_comb begin
    legal      = 1'b1;
    base_mask  = 8'h00;
    sized_data = 32'h0;
    case (x_st_funct3_i)
      3'b000: begin
        base_mask  = 8'b0000_0001;
        sized_data = {24'h0, x_st_data_i[7:0]};
      end
      3'b001: begin
        base_mask  = 8'b0000_0011;
        sized_data = {16'h0, x_st_data_i[15:0]};
      end
      3'b010: begin
        base_mask  = 8'b0000_1111;
        sized_data = x_st_data_i;
      end
      default: legal = 1'b0;
    endcase
    lane_mask = base_mask << x_st_addr_i[1:0];
    wide_data = {32'h0, sized_data} << {x_st_addr_i[1:0], 3'b000};
  end

  assign crosses      = |lane_mask[7:4];
  assign issuable     = legal && (!crosses || SplitEn);
  assign x_st_ready_o = (state_q == IDLE);
  assign accept       = x_st_valid_i && x_st_ready_o;
  assign busy_o       = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      dm_req_o   <= 1'b0;
      dm_addr_o  <= 32'h0;
      dm_wdata_o <= 32'h0;
      dm_be_o    <= 4'h0;
      hi_be_q    <= 4'h0;
      hi_wdata_q <= 32'h0;
      err_o      <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (issuable) begin
              state_q    <= BEAT1;
              dm_req_o   <= 1'b1;
              dm_addr_o  <= {x_st_addr_i[31:2], 2'b00};
              dm_be_o    <= lane_mask[3:0];
              dm_wdata_o <= wide_data[31:0];
              hi_be_q    <= lane_mask[7:4];
              hi_wdata_q <= wide_data[63:32];
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (dm_gnt_i) begin
            if (|hi_be_q) begin
              state_q    <= BEAT2;
              dm_addr_o  <= dm_addr_o + 32'd4;
              dm_be_o    <= hi_be_q;
              dm_wdata_o <= hi_wdata_q;
            end else begin
              state_q    <= IDLE;
              dm_req_o   <= 1'b0;
              dm_addr_o  <= 32'h0;
              dm_be_o    <= 4'h0;
              dm_wdata_o <= 32'h0;
            end
          end
        end
        BEAT2: begin
          if (dm_gnt_i) begin
            state_q    <= IDLE;
            dm_req_o   <= 1'b0;
            dm_addr_o  <= 32'h0;
            dm_be_o    <= 4'h0;
            dm_wdata_o <= 32'h0;
          end
        end
        default: begin
          state_q    <= IDLE;
          dm_req_o   <= 1'b0;
          dm_addr_o  <= 32'h0;
          dm_be_o    <= 4'h0;
          dm_wdata_o <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: instance 0 drops misaligned stores, instance 1 splits them.
module tb_store_align_unit;

  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        valid    [2];
  logic        ready    [2];
  logic [31:0] st_addr  [2];
  logic [31:0] st_data  [2];
  logic [2:0]  st_f3    [2];
  logic        req      [2];
  logic        gnt      [2];
  logic [31:0] dm_addr  [2];
  logic [31:0] dm_wdata [2];
  logic [3:0]  dm_be    [2];
  logic        busy     [2];
  logic        err      [2];

  exp_t sb [2][$];
  int   errors = 0;
  int   checks = 0;
  bit   gnt_rand = 0;

  store_align_unit #(.SPLIT_MISALIGNED(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .x_st_valid_i(valid[0]), .x_st_ready_o(ready[0]),
    .x_st_addr_i(st_addr[0]), .x_st_data_i(st_data[0]), .x_st_funct3_i(st_f3[0]),
    .dm_req_o(req[0]), .dm_gnt_i(gnt[0]), .dm_addr_o(dm_addr[0]),
    .dm_wdata_o(dm_wdata[0]), .dm_be_o(dm_be[0]), .busy_o(busy[0]), .err_o(err[0])
  );

  store_align_unit #(.SPLIT_MISALIGNED(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .x_st_valid_i(valid[1]), .x_st_ready_o(ready[1]),
    .x_st_addr_i(st_addr[1]), .x_st_data_i(st_data[1]), .x_st_funct3_i(st_f3[1]),
    .dm_req_o(req[1]), .dm_gnt_i(gnt[1]), .dm_addr_o(dm_addr[1]),
    .dm_wdata_o(dm_wdata[1]), .dm_be_o(dm_be[1]), .busy_o(busy[1]), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_beat(int i, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    exp_t e;
    e.is_err = 1'b0; e.addr = a; e.be = be; e.wdata = wd;
    sb[i].push_back(e);
  endfunction

  function automatic void push_err(int i);
    exp_t e;
    e.is_err = 1'b1; e.addr = 32'h0; e.be = 4'h0; e.wdata = 32'h0;
    sb[i].push_back(e);
  endfunction

  // Byte-level reference: store byte j lands in lane (offset + j) of an 8-lane window.
  function automatic void model(int i, logic [31:0] a, logic [31:0] d, logic [2:0] f3);
    int          s;
    int          o;
    logic [7:0]  lane [8];
    logic [7:0]  en;
    logic [31:0] base;
    s = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    o = int'(a[1:0]);
    if (s == 0 || (o + s > 4 && i == 0)) begin
      push_err(i);
      return;
    end
    en = 8'h0;
    for (int k = 0; k < 8; k++) begin
      lane[k] = 8'h0;
      if (k >= o && k < o + s) begin
        en[k]   = 1'b1;
        lane[k] = d[8*(k-o) +: 8];
      end
    end
    base = a & 32'hFFFF_FFFC;
    push_beat(i, base, en[3:0], {lane[3], lane[2], lane[1], lane[0]});
    if (en[7:4] != 4'h0)
      push_beat(i, base + 32'd4, en[7:4], {lane[7], lane[6], lane[5], lane[4]});
  endfunction

  // Drives one request; returns after the accepting edge (+1) with valid dropped.
  task automatic send(int i, logic [31:0] a, logic [31:0] d, logic [2:0] f3, bit use_model);
    int n;
    n = 0;
    while (!ready[i] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready[i]) begin
      chk("ready_timeout", 64'(ready[i]), 64'd1);
      return;
    end
    valid[i] = 1'b1; st_addr[i] = a; st_data[i] = d; st_f3[i] = f3;
    if (use_model) model(i, a, d, f3);
    @(posedge clk); #1;
    valid[i] = 1'b0;
    st_addr[i] = $urandom; st_data[i] = $urandom; st_f3[i] = 3'($urandom);
  endtask

  always @(posedge clk) begin
    #1;
    if (gnt_rand)
      for (int i = 0; i < 2; i++) gnt[i] = ($urandom_range(0, 3) != 0);
  end

  // Monitor: stalled beats are compared against the queue head, granted beats pop it.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (req[i]) begin
        if (sb[i].size() == 0) begin
          chk("unexpected_beat", {32'h0, dm_addr[i]}, 64'hDEAD);
        end else begin
          chk("beat_kind", 64'(sb[i][0].is_err), 64'd0);
          chk("beat_addr", 64'(dm_addr[i]), 64'(sb[i][0].addr));
          chk("beat_be", 64'(dm_be[i]), 64'(sb[i][0].be));
          chk("beat_wdata", 64'(dm_wdata[i]), 64'(sb[i][0].wdata));
          if (gnt[i]) void'(sb[i].pop_front());
        end
      end else begin
        chk("idle_zero", {dm_addr[i], dm_wdata[i]} | 64'(dm_be[i]), 64'h0);
      end
      if (err[i]) begin
        if (sb[i].size() == 0) begin
          chk("unexpected_err", 64'(err[i]), 64'd0);
        end else begin
          chk("err_kind", 64'(sb[i][0].is_err), 64'd1);
          void'(sb[i].pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    logic [31:0] a;
    logic [2:0]  f3;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 0; st_addr[i] = 0; st_data[i] = 0; st_f3[i] = 0; gnt[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req", 64'(req[i]), 64'd0);
      chk("rst_ready", 64'(ready[i]), 64'd1);
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_err", 64'(err[i]), 64'd0);
      chk("rst_outs", {dm_addr[i], dm_wdata[i]} | 64'(dm_be[i]), 64'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SB at the top lane, grant held high.
    gnt[1] = 1'b1;
    push_beat(1, 32'h0000_1000, 4'b1000, 32'hDD00_0000);
    send(1, 32'h0000_1003, 32'hAABB_CCDD, 3'b000, 0);
    chk("sb_ready_low", 64'(ready[1]), 64'd0);
    chk("sb_busy", 64'(busy[1]), 64'd1);
    @(posedge clk); #1;
    chk("sb_ready_back", 64'(ready[1]), 64'd1);

    // SH with a three-cycle stall.
    gnt[1] = 1'b0;
    push_beat(1, 32'h0000_2000, 4'b1100, 32'h1234_0000);
    send(1, 32'h0000_2002, 32'hFFFF_1234, 3'b001, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sh_stall_req", 64'(req[1]), 64'd1);
    gnt[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Misaligned SW split into two beats.
    push_beat(1, 32'h0000_3000, 4'b1110, 32'h2233_4400);
    push_beat(1, 32'h0000_3004, 4'b0001, 32'h0000_0011);
    send(1, 32'h0000_3001, 32'h1122_3344, 3'b010, 0);
    repeat (3) @(posedge clk);
    #1;

    // Address wrap at the top of memory.
    push_beat(1, 32'hFFFF_FFFC, 4'b1100, 32'hBABE_0000);
    push_beat(1, 32'h0000_0000, 4'b0011, 32'h0000_CAFE);
    send(1, 32'hFFFF_FFFE, 32'hCAFE_BABE, 3'b010, 0);
    repeat (3) @(posedge clk);
    #1;

    // Same store on the non-splitting instance: error pulse only.
    gnt[0] = 1'b1;
    push_err(0);
    send(0, 32'hFFFF_FFFE, 32'hCAFE_BABE, 3'b010, 0);
    chk("nosplit_err", 64'(err[0]), 64'd1);
    chk("nosplit_ready", 64'(ready[0]), 64'd1);
    @(posedge clk); #1;
    chk("nosplit_err_drop", 64'(err[0]), 64'd0);

    // Illegal funct3.
    push_err(1);
    send(1, 32'h0000_4000, 32'h5555_5555, 3'b011, 0);
    chk("illegal_err", 64'(err[1]), 64'd1);
    chk("illegal_ready", 64'(ready[1]), 64'd1);
    @(posedge clk); #1;
    chk("illegal_err_pulse", 64'(err[1]), 64'd0);
    chk("illegal_no_req", 64'(req[1]), 64'd0);

    // Reset during a stalled first beat aborts the store.
    gnt[1] = 1'b0;
    push_beat(1, 32'h0000_3000, 4'b1110, 32'h2233_4400);
    send(1, 32'h0000_3001, 32'h1122_3344, 3'b010, 0);
    chk("abort_req_before", 64'(req[1]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_req_async", 64'(req[1]), 64'd0);
    chk("abort_ready", 64'(ready[1]), 64'd1);
    sb[1].delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gnt[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_beat", 64'(req[1]), 64'd0);

    // Randomized traffic against the reference model on both instances.
    gnt_rand = 1'b1;
    for (int t = 0; t < 300; t++) begin
      int i;
      i  = t % 2;
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      n  = $urandom_range(0, 11);
      f3 = (n < 8) ? 3'(n) : 3'b010;
      send(i, a, $urandom, f3, 1);
    end
    for (int i = 0; i < 2; i++) begin
      n = 0;
      while (sb[i].size() != 0 && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
      chk("drain", 64'(sb[i].size()), 64'd0);
    end
    gnt_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
